// File: rtl/xoroshiro128_rewind.sv
`timescale 1ns/1ps
// xoroshiro128_rewind
// Steps a xoroshiro128 state backwards N times, one inverse step per accepted
// beat, and emits s0+s1 of each recovered state. The emitted words are the
// forward generator's outputs in reverse order. The final internal state is
// the state N forward steps earlier.
module xoroshiro128_rewind #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] state0_in,
  input  logic [DATA_W-1:0] state1_in,
  input  logic [CNT_W-1:0]  steps,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] state0_out,
  output logic [DATA_W-1:0] state1_out,
  output logic              busy,
  output logic              done
);

  // Rotate/shift constants of the forward step (rotl 55, shl 14, rotl 36).
  // They are only meaningful for a 64-bit word.
  localparam int unsigned ROT_A = 55;
  localparam int unsigned SHL_B = 14;
  localparam int unsigned ROT_C = 36;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 64-bit circular rotate right.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v,
                                             input int unsigned       amt);
    rotr = (v >> amt) | (v << (DATA_W - amt));
  endfunction

  // Exact inverse of the forward transition. Undo rotl(t,36) to get t, then
  // undo rotl(s0,55)^t^(t<<14) to get s0, then s1 = t ^ s0.
  // The result is packed as {s0p, s1p}.
  function automatic logic [2*DATA_W-1:0] inv_step(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] s0p;
    logic [DATA_W-1:0] s1p;
    x   = rotr(b, ROT_C);
    s0p = rotr(a ^ x ^ (x << SHL_B), ROT_A);
    s1p = x ^ s0p;
    inv_step = {s0p, s1p};
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] s0_r;
  logic [DATA_W-1:0] s1_r;
  logic [DATA_W-1:0] result_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              out_valid_r;
  logic              done_r;
  logic              busy_r;

  logic [DATA_W-1:0] s0_nxt_s;
  logic [DATA_W-1:0] s1_nxt_s;
  logic [DATA_W-1:0] result_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              out_valid_nxt_s;
  logic              done_nxt_s;
  logic              busy_nxt_s;

  logic [2*DATA_W-1:0] inv_s;
  logic [DATA_W-1:0]   inv_s0_s;
  logic [DATA_W-1:0]   inv_s1_s;
  logic                free_s;
  logic                cnt_zero_s;

  // Datapath: one inverse step of the current state.
  always_comb begin
    inv_s    = inv_step(s0_r, s1_r);
    inv_s0_s = inv_s[2*DATA_W-1:DATA_W];
    inv_s1_s = inv_s[DATA_W-1:0];
  end

  // The output slot can take a new word when it is empty or being drained.
  always_comb begin
    free_s     = (!out_valid_r) || out_ready;
    cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
  end

  // Next-state and next-output logic. By default everything holds and done is low.
  always_comb begin
    state_nxt_s     = state_r;
    s0_nxt_s        = s0_r;
    s1_nxt_s        = s1_r;
    result_nxt_s    = result_r;
    cnt_nxt_s       = cnt_r;
    out_valid_nxt_s = out_valid_r;
    done_nxt_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        out_valid_nxt_s = 1'b0;
        if (start) begin
          s0_nxt_s    = state0_in;
          s1_nxt_s    = state1_in;
          cnt_nxt_s   = steps;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (free_s && !cnt_zero_s) begin
          s0_nxt_s        = inv_s0_s;
          s1_nxt_s        = inv_s1_s;
          result_nxt_s    = inv_s0_s + inv_s1_s;
          out_valid_nxt_s = 1'b1;
          cnt_nxt_s       = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (free_s && cnt_zero_s) begin
          out_valid_nxt_s = 1'b0;
          done_nxt_s      = 1'b1;
          state_nxt_s     = ST_IDLE;
        end else begin
          // Stalled: the consumer has not taken the pending word.
          state_nxt_s = ST_RUN;
        end
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        out_valid_nxt_s = 1'b0;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_RUN);
  end

  // State and output registers. A synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      s0_r        <= {DATA_W{1'b0}};
      s1_r        <= {DATA_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      s0_r        <= s0_nxt_s;
      s1_r        <= s1_nxt_s;
      result_r    <= result_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign state0_out = s0_r;
  assign state1_out = s1_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
